// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, defaults and types for the write-back arbiter.
package wb_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 3;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_STARVE_LIMIT = 4;
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_FIFO} gnt_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding multi-cycle results; head is registered (no bypass).
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [REG_W-1:0]  push_reg,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [REG_W-1:0]  head_reg,
  output logic [DATA_W-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0] cnt_d, cnt_q;
  logic push_ok, pop_ok;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head_reg = mem_q[rd_ptr_q].rd;
    head_data = mem_q[rd_ptr_q].data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{rd: push_reg, data: push_data};
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between the pipeline WB stage
// and queued multi-cycle results, with a starvation override for the queue head.
module wb_arbiter import wb_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mc_valid,
  input  logic [REG_W-1:0]  mc_reg,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              rf_wr_en,
  output logic [REG_W-1:0]  rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  logic full, empty;
  logic [REG_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  gnt_e gnt;
  logic [SW-1:0] starve_d, starve_q;
  logic rf_wr_en_d, rf_wr_en_q, err_d, err_q, stall_d, stall_q;
  logic [REG_W-1:0] rf_wr_reg_d, rf_wr_reg_q, held_reg_d, held_reg_q;
  logic [DATA_W-1:0] rf_wr_data_d, rf_wr_data_q, held_data_d, held_data_q;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mc_valid && mc_ready),
    .pop       (gnt == GNT_FIFO),
    .push_reg  (mc_reg),
    .push_data (mc_data),
    .full      (full),
    .empty     (empty),
    .head_reg  (head_reg),
    .head_data (head_data)
  );
  always_comb begin
    // The queue wins over a valid pipe only once its head has waited the limit.
    gnt = !rst ? GNT_NONE
        : (!empty && (starve_q == S_MAX || !pipe_valid)) ? GNT_FIFO
        : pipe_valid ? GNT_PIPE : GNT_NONE;
    mc_ready = rst && !full;
    pipe_stall = pipe_valid && gnt == GNT_FIFO;
    starve_d = (empty || gnt == GNT_FIFO) ? '0 : (starve_q == S_MAX) ? starve_q : starve_q + 1'b1;
    rf_wr_en_d = gnt != GNT_NONE;
    rf_wr_reg_d = gnt == GNT_FIFO ? head_reg : gnt == GNT_PIPE ? pipe_reg : rf_wr_reg_q;
    rf_wr_data_d = gnt == GNT_FIFO ? head_data : gnt == GNT_PIPE ? pipe_data : rf_wr_data_q;
    stall_d = pipe_stall;
    held_reg_d = pipe_reg;
    held_data_d = pipe_data;
    err_d = err_q || (stall_q && (!pipe_valid || pipe_reg != held_reg_q || pipe_data != held_data_q));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
      rf_wr_en_q <= 1'b0;
      rf_wr_reg_q <= '0;
      rf_wr_data_q <= '0;
      stall_q <= 1'b0;
      held_reg_q <= '0;
      held_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_wr_reg_q <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
      stall_q <= stall_d;
      held_reg_q <= held_reg_d;
      held_data_q <= held_data_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    rf_wr_en = rf_wr_en_q;
    rf_wr_reg = rf_wr_reg_q;
    rf_wr_data = rf_wr_data_q;
    err = err_q;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of arbitration, starvation, full FIFO, protocol error and reset.
module tb_wb_arbiter;
  logic clk = 1'b0, rst = 1'b0, pipe_valid = 1'b0, mc_valid = 1'b0;
  logic [2:0] pipe_reg = '0, mc_reg = '0;
  logic [15:0] pipe_data = '0, mc_data = '0;
  logic pipe_stall, mc_ready, rf_wr_en, err;
  logic [2:0] rf_wr_reg;
  logic [15:0] rf_wr_data;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall), .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
    .mc_ready(mc_ready), .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .err(err)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rf(input string tag, input logic en, input logic [2:0] r, input logic [15:0] d);
    chk({tag, ".en"}, 16'(en), 16'(1'b1 & en));
    chk({tag, ".en"}, 16'(rf_wr_en), 16'(en));
    chk({tag, ".reg"}, 16'(rf_wr_reg), 16'(r));
    chk({tag, ".data"}, rf_wr_data, d);
  endtask
  initial begin
    // reset with requests present: nothing accepted, nothing stalled
    pipe_valid = 1; mc_valid = 1; mc_reg = 2; mc_data = 16'hDEAD;
    #1;
    chk("rst_stall", 16'(pipe_stall), 0);
    chk("rst_ready", 16'(mc_ready), 0);
    tick; tick;
    rf("rst", 0, 0, 16'h0000);
    chk("rst_err", 16'(err), 0);
    rst = 1; pipe_valid = 0; mc_valid = 0;
    // pipe only
    pipe_valid = 1; pipe_reg = 3; pipe_data = 16'h00AB;
    #1;
    chk("pipe_stall", 16'(pipe_stall), 0);
    chk("pipe_ready", 16'(mc_ready), 1);
    tick;
    rf("pipe", 1, 3, 16'h00AB);
    pipe_valid = 0;
    tick;
    rf("idle_hold", 0, 3, 16'h00AB);
    // mc only, no bypass
    mc_valid = 1; mc_reg = 5; mc_data = 16'h1234;
    tick;
    mc_valid = 0;
    rf("mc_nobypass", 0, 3, 16'h00AB);
    tick;
    rf("mc", 1, 5, 16'h1234);
    tick;
    rf("mc_idle", 0, 5, 16'h1234);
    // starvation
    pipe_valid = 1; pipe_reg = 1; pipe_data = 16'h0011;
    mc_valid = 1; mc_reg = 6; mc_data = 16'h6666;
    tick;
    mc_valid = 0;
    rf("starve_push", 1, 1, 16'h0011);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("starve_wait_stall", 16'(pipe_stall), 0);
      tick;
      rf("starve_wait", 1, 1, 16'h0011);
    end
    #1;
    chk("starve_stall", 16'(pipe_stall), 1);
    tick;
    rf("starve_fifo", 1, 6, 16'h6666);
    #1;
    chk("starve_resume_stall", 16'(pipe_stall), 0);
    tick;
    rf("starve_resume", 1, 1, 16'h0011);
    chk("starve_err", 16'(err), 0);
    // full FIFO holds off a third entry
    pipe_reg = 2; pipe_data = 16'h0022;
    mc_valid = 1; mc_reg = 7; mc_data = 16'h0A01;
    tick;
    mc_data = 16'h0A02;
    tick;
    mc_data = 16'h0A03;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_ready", 16'(mc_ready), 0);
      chk("full_stall", 16'(pipe_stall), 0);
      tick;
      rf("full_pipe", 1, 2, 16'h0022);
    end
    #1;
    chk("full_pop_stall", 16'(pipe_stall), 1);
    chk("full_pop_ready", 16'(mc_ready), 0);
    tick;
    rf("full_pop", 1, 7, 16'h0A01);
    #1;
    chk("after_pop_ready", 16'(mc_ready), 1);
    tick;
    rf("third_push", 1, 2, 16'h0022);
    mc_valid = 0; pipe_valid = 0;
    tick;
    rf("drain2", 1, 7, 16'h0A02);
    tick;
    rf("drain3", 1, 7, 16'h0A03);
    tick;
    rf("drained", 0, 7, 16'h0A03);
    chk("full_err", 16'(err), 0);
    // reset mid-operation with two entries queued
    pipe_valid = 1; pipe_reg = 4; pipe_data = 16'h0044;
    mc_valid = 1; mc_reg = 1; mc_data = 16'hB001;
    tick;
    mc_data = 16'hB002;
    tick;
    mc_valid = 0;
    rst = 0;
    #1;
    chk("mid_rst_ready", 16'(mc_ready), 0);
    chk("mid_rst_stall", 16'(pipe_stall), 0);
    tick;
    rf("mid_rst", 0, 0, 16'h0000);
    rst = 1; pipe_valid = 0;
    #1;
    chk("post_rst_ready", 16'(mc_ready), 1);
    tick;
    rf("post_rst_nowrite", 0, 0, 16'h0000);
    pipe_valid = 1; pipe_reg = 4; pipe_data = 16'h0044;
    mc_valid = 1; mc_reg = 5; mc_data = 16'hC003;
    tick;
    mc_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("restart_wait_stall", 16'(pipe_stall), 0);
      tick;
    end
    #1;
    chk("restart_stall", 16'(pipe_stall), 1);
    tick;
    rf("restart_fifo", 1, 5, 16'hC003);
    // protocol violation: data changed while stalled
    pipe_data = 16'h0045;
    #1;
    chk("proto_err_pre", 16'(err), 0);
    tick;
    chk("proto_err", 16'(err), 1);
    rf("proto_pipe", 1, 4, 16'h0045);
    pipe_valid = 0;
    tick;
    chk("proto_err_sticky", 16'(err), 1);
    rst = 0;
    tick;
    chk("proto_err_clr", 16'(err), 0);
    rst = 1;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
